host_line_responder: RTL and testbench
======================================

// Module: host_line_responder
// PURPOSE
//  Responder end of the cache-line host interface driven by the CPU cache controller (op/addr/512b line out; line/rd_valid/tx_done back).
//  Accepts one line read or write, splits it into BEATS x BEAT_W beats on a ready/valid memory port, reassembles read beats into a line.
//  Sits between mem_system's host-side ports and the backing memory/DMA fabric.
// PARAMETERS
//  ADDR_W   32    byte address width
//  LINE_W   512   cache line width (bits)
//  BEAT_W   64    memory beat width; BEATS = LINE_W/BEAT_W = 8, must divide evenly
//  TIMEOUT  1024  max cycles waiting on mem_rsp_valid (only with HLR_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       async active-low reset
//  op_host        in   2       00 idle, 01 line read, 10 line write, 11 reserved (ignored)
//  AddrOut_host   in   ADDR_W  line address from requester; low log2(LINE_W/8) bits ignored
//  DataOut_host   in   LINE_W  write line from requester
//  DataIn_host    out  LINE_W  read line to requester
//  rd_valid_host  out  1       1-cycle pulse: DataIn_host holds a completed read line
//  tx_done_host   out  1       1-cycle pulse: current read or write finished
//  err_host       out  1       1-cycle pulse with tx_done_host on timeout abort (tied 0 without macro)
//  mem_req_valid  out  1       beat request valid
//  mem_req_ready  in   1       memory accepts request when valid&ready
//  mem_req_wr     out  1       1 write beat, 0 read beat
//  mem_req_addr   out  ADDR_W  beat byte address
//  mem_req_wdata  out  BEAT_W  write beat data
//  mem_rsp_valid  in   1       read beat returned, in request order
//  mem_rsp_rdata  in   BEAT_W  read beat data
// BEHAVIOUR
//  - Clock/reset: clk, rst_n; async active-low. Reset: all outputs 0, DataIn_host 0, state IDLE, counters 0, armed=1.
//  - FSM: IDLE -> RD (op=01) | WR (op=10) -> DONE -> IDLE.
//  - IDLE: accept when armed & op in {01,10}; latch base = addr with low 6 bits zeroed, latch write line; armed<=0.
//    armed<=1 on any cycle op==00 seen (any state). A held op after completion starts no second transaction.
//  - op/addr/data changes after acceptance are ignored until DONE.
//  - Beat i address = base + i*(BEAT_W/8); beat i data = line[i*BEAT_W +: BEAT_W] (beat 0 = LSBs).
//  - RD: mem_req_valid=1, wr=0 while req_cnt<BEATS; req_cnt++ per valid&ready. Pipelined: up to BEATS outstanding.
//    Each mem_rsp_valid writes beat rsp_cnt into rd line buffer, rsp_cnt++. After beat BEATS-1 -> DONE.
//    First response may arrive the cycle after first accepted request; a response cycle may coincide with a request handshake.
//  - WR: mem_req_valid=1, wr=1; after handshake of beat BEATS-1 -> DONE. No write response expected.
//  - mem_req_valid, addr, wdata held stable until handshake (valid never drops without ready).
//  - mem_rsp_valid outside RD, or after rsp_cnt==BEATS, ignored.
//  - DONE (1 cycle): tx_done_host=1; if read, rd_valid_host=1 and DataIn_host<=buffer (registered, visible same cycle as pulse),
//    held until next read completes. Write leaves DataIn_host unchanged.
//  - Latency, 0-wait memory, 1-cycle rsp: read accept->pulse = BEATS+2 cycles; write = BEATS+1.
//  - Counters width $clog2(BEATS)+1; no wrap within a line; base+offset never carries past line (aligned).
//  - Reset mid-transaction: abort immediately, no pulses; in-flight memory responses after reset are dropped (memory reset together).
// CONFIGURATION
//  HLR_TIMEOUT_EN defined: in RD, cycle counter clears on each mem_rsp_valid and on RD entry; reaching TIMEOUT
//    -> DONE with tx_done_host=1, rd_valid_host=0, err_host=1; DataIn_host unchanged; late responses ignored.
//  HLR_TIMEOUT_EN undefined: no counter, RD waits indefinitely, err_host constant 0.
// TESTING
//  1 Read addr 0x0000_1047, mem returns beat i=64'hA0+i, ready=1 -> req addrs 0x1040..0x1078 step 8;
//    DataIn_host[63:0]=A0..[511:448]=A7; rd_valid&tx_done one pulse at accept+10.
//  2 Write addr 0x2000, line beat i=64'h1111_0000+i, ready toggling 1010.. -> 8 wr beats 0x2000..0x2038 in order,
//    data stable under stall; tx_done pulse only, rd_valid=0.
//  3 op=01 held 20 cycles after tx_done -> exactly one read; drop op to 00 one cycle, op=10 -> write accepted.
//  4 Responses delayed 5 cycles, requests all issued back-to-back -> 8 outstanding, line assembled correctly.
//  5 rst_n low at rsp beat 4 of a read -> outputs 0 async, no pulse; new read after release completes normally.
//  6 HLR_TIMEOUT_EN, TIMEOUT=16, mem stops after beat 3 -> tx_done&err_host pulse 16 cycles after beat 3, rd_valid=0.

Source files
------------

// File: rtl/host_line_responder.sv
// Responder side of the cache-line host interface: splits one line read/write into beats on a
// ready/valid memory port and reassembles read beats. Optional read timeout via HLR_TIMEOUT_EN.
module host_line_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int BEAT_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        op_host,
    input  logic [ADDR_W-1:0] AddrOut_host,
    input  logic [LINE_W-1:0] DataOut_host,
    output logic [LINE_W-1:0] DataIn_host,
    output logic              rd_valid_host,
    output logic              tx_done_host,
    output logic              err_host,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [BEAT_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [BEAT_W-1:0] mem_rsp_rdata
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int BEAT_B = BEAT_W / 8;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

    if ((LINE_W % BEAT_W) != 0 || BEATS < 2 || TIMEOUT < 2) begin : g_cfg_check
        $error("host_line_responder: unsupported LINE_W/BEAT_W/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rbuf_q, rbuf_d;
    logic [LINE_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic              tx_done_q, tx_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic              req_hs_s;
    logic              rsp_take_s;
    logic              timeout_s;

    // Beat request is driven straight from registered state, so it stays stable under stall
    assign mem_req_valid = ((state_q == S_RD) || (state_q == S_WR)) && (req_cnt_q < BEATS_C);
    assign mem_req_wr    = (state_q == S_WR);
    assign mem_req_addr  = base_q + (ADDR_W'(req_cnt_q) << $clog2(BEAT_B));
    assign mem_req_wdata = wline_q[int'(req_cnt_q[CNT_W-2:0]) * BEAT_W +: BEAT_W];
    assign req_hs_s      = mem_req_valid && mem_req_ready;
    assign rsp_take_s    = (state_q == S_RD) && mem_rsp_valid && (rsp_cnt_q < BEATS_C);

    assign DataIn_host   = din_q;
    assign rd_valid_host = rd_valid_q;
    assign tx_done_host  = tx_done_q;
    assign err_host      = err_q;

`ifdef HLR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts cycles since RD entry or the last accepted response; restart value 1 counts that cycle
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_IDLE) begin
            tmo_d = TMO_W'(1);
        end else if (rsp_take_s) begin
            tmo_d = TMO_W'(1);
        end else if (state_q == S_RD) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_s = (state_q == S_RD) && !rsp_take_s && (tmo_q == TMO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, beat bookkeeping and completion pulses
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wline_d    = wline_q;
        rbuf_d     = rbuf_q;
        din_d      = din_q;
        tx_done_d  = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        if (req_hs_s) begin
            req_cnt_d = req_cnt_q + 1'b1;
        end else begin
            req_cnt_d = req_cnt_q;
        end
        if (rsp_take_s) begin
            rbuf_d[int'(rsp_cnt_q[CNT_W-2:0]) * BEAT_W +: BEAT_W] = mem_rsp_rdata;
            rsp_cnt_d = rsp_cnt_q + 1'b1;
        end else begin
            rsp_cnt_d = rsp_cnt_q;
        end
        // Re-arming needs an idle op, so a held request never starts a second transaction
        if (op_host == 2'b00) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        case (state_q)
            S_IDLE: begin
                if (armed_q && ((op_host == 2'b01) || (op_host == 2'b10))) begin
                    state_d   = (op_host == 2'b01) ? S_RD : S_WR;
                    armed_d   = 1'b0;
                    base_d    = AddrOut_host & ~ADDR_W'(LINE_W / 8 - 1);
                    wline_d   = DataOut_host;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (timeout_s) begin
                    state_d   = S_DONE;
                    tx_done_d = 1'b1;
                    err_d     = 1'b1;
                end else if (rsp_take_s && (rsp_cnt_q == LAST_C)) begin
                    state_d    = S_DONE;
                    tx_done_d  = 1'b1;
                    rd_valid_d = 1'b1;
                    din_d      = rbuf_d;
                end else begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (req_hs_s && (req_cnt_q == LAST_C)) begin
                    state_d   = S_DONE;
                    tx_done_d = 1'b1;
                end else begin
                    state_d = S_WR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            base_q     <= '0;
            wline_q    <= '0;
            rbuf_q     <= '0;
            din_q      <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            tx_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            base_q     <= base_d;
            wline_q    <= wline_d;
            rbuf_q     <= rbuf_d;
            din_q      <= din_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            tx_done_q  <= tx_done_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_host_line_responder.sv
// Directed bench for host_line_responder: a behavioural memory answers beat requests and each
// scenario task checks latency, pulses, beat order and the assembled line against hand-derived values.
module tb_host_line_responder;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int BEAT_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        op_host = 2'b00;
    logic [ADDR_W-1:0] AddrOut_host = '0;
    logic [LINE_W-1:0] DataOut_host = '0;
    logic [LINE_W-1:0] DataIn_host;
    logic              rd_valid_host, tx_done_host, err_host;
    logic              mem_req_valid, mem_req_wr;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [BEAT_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid = 1'b0;
    logic [BEAT_W-1:0] mem_rsp_rdata = '0;

    host_line_responder #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_host(op_host), .AddrOut_host(AddrOut_host),
        .DataOut_host(DataOut_host), .DataIn_host(DataIn_host), .rd_valid_host(rd_valid_host),
        .tx_done_host(tx_done_host), .err_host(err_host), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // memory model controls and logs
    int          cyc = 0;
    int          rsp_delay = 1;
    int          rsp_limit = 8;
    bit          ready_toggle = 1'b0;
    bit          tog = 1'b1;
    int          max_out = 0;
    logic [63:0] rd_pat = '0;
    logic [63:0] rsp_data_q[$];
    int          rsp_due_q[$];
    logic [31:0] log_addr[$];
    logic [63:0] log_data[$];
    logic        log_wr[$];
    int          log_cyc[$];

    function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] pat);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = pat + 64'(i);
        return l;
    endfunction

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_wr.delete(); log_cyc.delete();
        max_out = 0;
    endtask

    // Memory: drives ready/responses on the falling edge, read beat data = rd_pat + beat index
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            mem_rsp_valid = 1'b0;
            if (!rst_n) begin
                rsp_data_q.delete(); rsp_due_q.delete();
                mem_req_ready = 1'b0;
            end else begin
                mem_req_ready = ready_toggle ? tog : 1'b1;
                tog = ~tog;
                if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rsp_data_q.pop_front();
                    void'(rsp_due_q.pop_front());
                end
                if (mem_req_valid && mem_req_ready) begin
                    log_addr.push_back(mem_req_addr); log_data.push_back(mem_req_wdata);
                    log_wr.push_back(mem_req_wr); log_cyc.push_back(cyc);
                    if (!mem_req_wr && int'(mem_req_addr[5:3]) < rsp_limit) begin
                        rsp_data_q.push_back(rd_pat + 64'(mem_req_addr[5:3]));
                        rsp_due_q.push_back(cyc + rsp_delay);
                    end
                    if (rsp_due_q.size() > max_out) max_out = rsp_due_q.size();
                end
            end
        end
    end

    task automatic wait_pulse(input int max_cyc, output int seen, output logic rdv, output logic er);
        seen = -1; rdv = 1'b0; er = 1'b0;
        for (int k = 1; k <= max_cyc && seen < 0; k++) begin
            @(negedge clk); #1;
            if (tx_done_host) begin
                seen = k; rdv = rd_valid_host; er = err_host;
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [LINE_W-1:0] line);
        op_host = 2'b00;
        @(negedge clk); #1;
        op_host = op; AddrOut_host = addr; DataOut_host = line;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({DataIn_host, rd_valid_host, tx_done_host, err_host, mem_req_valid, mem_req_wr} !== '0)
            $display("FAIL reset_outputs: got nonzero din/pulses/valid, expected all 0");
        else n_pass++;
        n_chk++;
        if ({mem_req_addr, mem_req_wdata} !== '0)
            $display("FAIL reset_req_bus: addr=%h wdata=%h expected 0", mem_req_addr, mem_req_wdata);
        else n_pass++;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int seen; logic rdv, er; bit bad;
        rd_pat = 64'hA0; rsp_delay = 1; ready_toggle = 1'b0; clear_logs();
        issue(2'b01, 32'h0000_1047, {8{64'hDEAD_BEEF_0000_0000}});
        wait_pulse(40, seen, rdv, er);
        n_chk++;
        if (seen !== 10) $display("FAIL rd_latency: got %0d expected 10", seen); else n_pass++;
        n_chk++;
        if ({rdv, er} !== 2'b10) $display("FAIL rd_pulses: rd_valid/err=%b expected 10", {rdv, er}); else n_pass++;
        n_chk++;
        if (DataIn_host !== mk_line(64'hA0)) $display("FAIL rd_line: got %h expected %h", DataIn_host, mk_line(64'hA0));
        else n_pass++;
        @(negedge clk); #1;
        n_chk++;
        if ({tx_done_host, rd_valid_host} !== 2'b00) $display("FAIL rd_pulse_width: got %b expected 00", {tx_done_host, rd_valid_host});
        else n_pass++;
        bad = (log_addr.size() != 8);
        for (int i = 0; i < log_addr.size() && i < 8; i++)
            if (log_addr[i] !== 32'h1040 + 32'(i * 8) || log_wr[i] !== 1'b0) bad = 1'b1;
        n_chk++;
        if (bad) $display("FAIL rd_beat_addrs: %0d beats, first %h, expected 8 reads 0x1040..0x1078", log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 32'h0);
        else n_pass++;
    endtask

    task automatic test_held_op();
        int pulses = 0; int seen; logic rdv, er;
        clear_logs();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (tx_done_host) pulses++;
        end
        n_chk++;
        if (pulses != 0 || log_addr.size() != 0)
            $display("FAIL held_op: pulses=%0d beats=%0d expected 0/0", pulses, log_addr.size());
        else n_pass++;
        issue(2'b10, 32'h0000_3000, mk_line(64'h3300));
        wait_pulse(40, seen, rdv, er);
        n_chk++;
        if (seen !== 9 || rdv !== 1'b0 || log_addr.size() != 8)
            $display("FAIL rearm_write: latency=%0d rd_valid=%b beats=%0d expected 9/0/8", seen, rdv, log_addr.size());
        else n_pass++;
    endtask

    task automatic test_write();
        bit done = 1'b0; bit bad = 1'b0; bit prev_stall = 1'b0;
        int stalls = 0; int stall_bad = 0; logic rdv = 1'b0;
        logic [31:0] s_addr; logic [63:0] s_data;
        ready_toggle = 1'b1; clear_logs();
        issue(2'b10, 32'h0000_2000, mk_line(64'h1111_0000));
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk); #1;
            if (prev_stall) begin
                stalls++;
                if (!mem_req_valid || mem_req_addr !== s_addr || mem_req_wdata !== s_data) stall_bad++;
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            s_addr = mem_req_addr; s_data = mem_req_wdata;
            if (tx_done_host) begin done = 1'b1; rdv = rd_valid_host; end
        end
        n_chk++;
        if (!done || rdv !== 1'b0) $display("FAIL wr_done: done=%0d rd_valid=%b expected 1/0", done, rdv); else n_pass++;
        n_chk++;
        if (stalls == 0 || stall_bad != 0) $display("FAIL wr_stall_stable: stalls=%0d unstable=%0d expected >0/0", stalls, stall_bad);
        else n_pass++;
        bad = (log_addr.size() != 8);
        for (int i = 0; i < log_addr.size() && i < 8; i++)
            if (log_addr[i] !== 32'h2000 + 32'(i * 8) || log_wr[i] !== 1'b1 || log_data[i] !== 64'h1111_0000 + 64'(i)) bad = 1'b1;
        n_chk++;
        if (bad) $display("FAIL wr_beats: %0d beats, expected 8 writes 0x2000..0x2038 data 11110000+i", log_addr.size());
        else n_pass++;
        n_chk++;
        if (DataIn_host !== mk_line(64'hA0)) $display("FAIL wr_keeps_din: got %h expected %h", DataIn_host, mk_line(64'hA0));
        else n_pass++;
        ready_toggle = 1'b0;
    endtask

    task automatic test_pipelined();
        int seen; logic rdv, er;
        // first response lands five cycles after the eighth request
        rd_pat = 64'hC0_0000; rsp_delay = 12; clear_logs();
        issue(2'b01, 32'h0000_4000, '0);
        wait_pulse(60, seen, rdv, er);
        n_chk++;
        if (seen !== 21 || rdv !== 1'b1) $display("FAIL pipe_latency: got %0d rd_valid=%b expected 21/1", seen, rdv); else n_pass++;
        n_chk++;
        if (max_out != 8 || log_cyc.size() != 8 || log_cyc[7] - log_cyc[0] != 7)
            $display("FAIL pipe_outstanding: max=%0d beats=%0d expected 8 back-to-back", max_out, log_cyc.size());
        else n_pass++;
        n_chk++;
        if (DataIn_host !== mk_line(64'hC0_0000)) $display("FAIL pipe_line: got %h expected %h", DataIn_host, mk_line(64'hC0_0000));
        else n_pass++;
        rsp_delay = 1;
    endtask

    task automatic test_reset_mid();
        int seen; int pulses = 0; logic rdv, er;
        rd_pat = 64'hD0; clear_logs();
        issue(2'b01, 32'h0000_5000, '0);
        repeat (6) begin @(negedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({DataIn_host, rd_valid_host, tx_done_host, mem_req_valid} !== '0)
            $display("FAIL mid_reset_async: outputs nonzero, expected 0");
        else n_pass++;
        rd_pat = 64'hE0;
        AddrOut_host = 32'h0000_6000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (tx_done_host || rd_valid_host) pulses++;
        end
        clear_logs();
        rst_n = 1'b1;
        wait_pulse(40, seen, rdv, er);
        n_chk++;
        if (pulses != 0 || seen !== 10 || rdv !== 1'b1)
            $display("FAIL mid_reset_recover: pulses=%0d latency=%0d rd_valid=%b expected 0/10/1", pulses, seen, rdv);
        else n_pass++;
        n_chk++;
        if (DataIn_host !== mk_line(64'hE0)) $display("FAIL mid_reset_line: got %h expected %h", DataIn_host, mk_line(64'hE0));
        else n_pass++;
    endtask

`ifdef HLR_TIMEOUT_EN
    task automatic test_timeout();
        int seen; logic rdv, er;
        rd_pat = 64'hF0; rsp_limit = 4; clear_logs();
        issue(2'b01, 32'h0000_7000, '0);
        wait_pulse(60, seen, rdv, er);
        n_chk++;
        if (seen !== 21 || {rdv, er} !== 2'b01)
            $display("FAIL timeout_pulse: latency=%0d rd_valid/err=%b expected 21/01", seen, {rdv, er});
        else n_pass++;
        n_chk++;
        if (DataIn_host !== mk_line(64'hE0)) $display("FAIL timeout_din: got %h expected %h", DataIn_host, mk_line(64'hE0));
        else n_pass++;
        rsp_limit = 8;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_held_op();
        test_write();
        test_pipelined();
        test_reset_mid();
`ifdef HLR_TIMEOUT_EN
        test_timeout();
`endif
        op_host = 2'b00;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
